// File: rtl/cmd_fifo_reader.sv
// Pops one command entry from a FIFO and streams it as 32-bit words; word 0 is the header, header[7:0] = payload words.
// Latency: first stream word is valid 2 cycles after the pop strobe (pop -> WAIT capture -> SEND).
// Backpressure: out_ready low holds out_data/out_last stable; no new pop until the packet finishes. Optional macro: CMD_FIFO_READER_PKT_COUNT_EN.
module cmd_fifo_reader #(
  parameter int WIDTH = 256
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic [8*WIDTH-1:0] fifo_data,
  output logic               fifo_rd_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               out_last,
  output logic               busy,
  output logic               err_len,
  output logic [15:0]        pkt_count
);

  localparam int WORDS = 8 * WIDTH / 32;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] MAX_L = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [8*WIDTH-1:0] r_pkt;
  logic [IDX_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_idx;
  logic               r_rst_d;

  logic               w_pop;
  logic               w_err;
  logic               w_hs;
  logic               w_last;
  logic [7:0]         w_hdr_len;
  logic               w_len_ovf;
  logic [IDX_W-1:0]   w_len_clamp;
  logic [31:0]        w_words [WORDS];

  // Slice the captured entry into addressable 32-bit words.
  for (genvar k = 0; k < WORDS; k++) begin : g_words
    assign w_words[k] = r_pkt[32*k +: 32];
  end

  // Length field comes straight from the FIFO read data; it is only consumed in WAIT.
  assign w_hdr_len   = fifo_data[7:0];
  assign w_len_ovf   = int'({24'd0, w_hdr_len}) > (WORDS - 1);
  assign w_len_clamp = w_len_ovf ? MAX_L : IDX_W'(w_hdr_len);

  assign w_hs   = (r_state == SEND) && out_ready;
  assign w_last = (r_idx == r_len);

  // Next-state and pop decision; a pop is also blocked in the cycle right after reset.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !fifo_empty && !r_rst_d) begin
          w_pop        = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        w_err        = w_len_ovf;
        w_next_state = SEND;
      end
      SEND: begin
        if (w_hs && w_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register; reset drops any packet in flight.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Remember that the previous cycle was in reset so the first IDLE cycle stays quiet.
  always_ff @(posedge CLK) begin
    r_rst_d <= rst;
  end

  // Capture the entry in WAIT, then walk the word index on each accepted word.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_pkt <= '0;
      r_len <= '0;
      r_idx <= '0;
    end else if (r_state == WAIT) begin
      r_pkt <= fifo_data;
      r_len <= w_len_clamp;
      r_idx <= '0;
    end else if (w_hs && !w_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // All outputs are forced quiet while reset is asserted.
  assign fifo_rd_en = w_pop && !rst;
  assign out_valid  = (r_state == SEND) && !rst;
  assign out_last   = (r_state == SEND) && w_last && !rst;
  assign busy       = (r_state != IDLE) && !rst;
  assign err_len    = w_err && !rst;
  assign out_data   = rst ? 32'd0 : w_words[r_idx];

`ifdef CMD_FIFO_READER_PKT_COUNT_EN
  logic [15:0] r_pkt_count;

  // Count packets whose final word was accepted; wraps naturally.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_pkt_count <= 16'd0;
    end else if (w_hs && w_last) begin
      r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign pkt_count = r_pkt_count;
`else
  assign pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_cmd_fifo_reader.sv
// Bench for cmd_fifo_reader: FIFO model, word-stream scoreboard and per-scenario tasks.
// The FIFO model returns registered data the cycle after a pop and garbage otherwise.
// Expected words are derived from each popped entry's length field with clamping.
module tb_cmd_fifo_reader;

  localparam int WIDTH = 256;
  localparam int WORDS = 8 * WIDTH / 32;
  localparam int DW    = 8 * WIDTH;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          err_len;
  logic [15:0]   pkt_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] fifo_q[$];
  int            fifo_cnt = 0;
  logic [31:0]   exp_q[$];
  logic          exp_last_q[$];
  int            pop_cyc_q[$];
  int            err_exp  = 0;
  int            err_seen = 0;
  int            words_seen = 0;
  logic [15:0]   pkt_exp = 16'd0;

  logic          prev_stall = 1'b0;
  logic          prev_rd    = 1'b0;
  logic          prev_valid = 1'b0;
  logic [31:0]   prev_data  = 32'd0;
  logic          prev_last  = 1'b0;

  always #5 CLK = ~CLK;

  assign fifo_empty = (fifo_cnt == 0);

  cmd_fifo_reader #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err_len    (err_len),
    .pkt_count  (pkt_count)
  );

  // FIFO model: pop on strobe, queue the expected words of the popped entry.
  always @(posedge CLK) begin
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    int n;
    if (fifo_rd_en && fifo_q.size() > 0) begin
      e = fifo_q.pop_front();
      fifo_data <= e;
      fifo_cnt  <= fifo_cnt - 1;
      n = int'(e[7:0]);
      if (n > WORDS - 1) begin
        n = WORDS - 1;
        err_exp++;
      end
      for (int k = 0; k <= n; k++) begin
        exp_q.push_back(e[32*k +: 32]);
        exp_last_q.push_back(k == n);
      end
    end else begin
      for (int k = 0; k < WORDS; k++) g[32*k +: 32] = $urandom;
      fifo_data <= g;
    end
  end

  // Stream scoreboard, sampled mid-cycle.
  always @(negedge CLK) begin
    logic [31:0] ew;
    logic        el;
    int          pc;
    cyc++;
    if (fifo_rd_en) begin
      pop_cyc_q.push_back(cyc);
      total++;
      if (prev_rd) begin
        bad++;
        $display("FAIL rd_en_single: strobe high at cycle %0d and the previous cycle", cyc);
      end
    end
    if (out_valid && !prev_valid) begin
      total++;
      if (pop_cyc_q.size() == 0) begin
        bad++;
        $display("FAIL latency: out_valid rose at cycle %0d with no pending pop", cyc);
      end else begin
        pc = pop_cyc_q.pop_front();
        if (cyc !== pc + 2) begin
          bad++;
          $display("FAIL latency: first valid at cycle %0d, expected %0d", cyc, pc + 2);
        end
      end
    end
    if (prev_stall) begin
      total++;
      if (!(out_valid === 1'b1 && out_data === prev_data && out_last === prev_last)) begin
        bad++;
        $display("FAIL hold: valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                 out_valid, out_data, out_last, prev_data, prev_last);
      end
    end
    if (out_valid && out_ready) begin
      words_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_word: got %h with nothing expected", out_data);
      end else begin
        ew = exp_q.pop_front();
        el = exp_last_q.pop_front();
        if (out_data !== ew || out_last !== el) begin
          bad++;
          $display("FAIL word: got data=%h last=%b, expected data=%h last=%b", out_data, out_last, ew, el);
        end
        if (el) pkt_exp = pkt_exp + 16'd1;
      end
    end
    if (err_len === 1'b1) err_seen++;
    prev_stall = out_valid && !out_ready;
    prev_rd    = fifo_rd_en;
    prev_valid = out_valid;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] make_entry(input logic [7:0] len);
    logic [DW-1:0] e;
    for (int k = 0; k < WORDS; k++) e[32*k +: 32] = $urandom;
    e[7:0] = len;
    return e;
  endfunction

  task automatic push(input logic [DW-1:0] e);
    fifo_q.push_back(e);
    fifo_cnt = fifo_cnt + 1;
  endtask

  function automatic bit drained();
    return (fifo_cnt == 0) && (exp_q.size() == 0) && !busy && !fifo_rd_en;
  endfunction

  task automatic flush_model();
    exp_q.delete();
    exp_last_q.delete();
    pop_cyc_q.delete();
    pkt_exp = 16'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    push(make_entry(8'd1));
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({fifo_rd_en, out_valid, out_last, busy, err_len} !== 5'b0 || out_data !== 32'd0 || pkt_count !== 16'd0) begin
        bad++;
        $display("FAIL reset_hold: rd=%b v=%b l=%b busy=%b err=%b data=%h cnt=%0d, expected all 0",
                 fifo_rd_en, out_valid, out_last, busy, err_len, out_data, pkt_count);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if ({fifo_rd_en, out_valid, out_last, busy, err_len} !== 5'b0 || out_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_after: rd=%b v=%b l=%b busy=%b err=%b data=%h, expected all 0",
               fifo_rd_en, out_valid, out_last, busy, err_len, out_data);
    end
    for (int i = 0; i < 100 && !drained(); i++) tick();
    total++;
    if (!drained()) begin
      bad++;
      $display("FAIL reset_drain: fifo_cnt=%0d pending=%0d busy=%b, expected drained", fifo_cnt, exp_q.size(), busy);
    end
  endtask

  task automatic test_single();
    int hs = 0;
    int w0 = words_seen;
    int e0 = err_seen;
    bit saw_last = 0;
    bit busy_ok = 0;
    enable = 1'b1;
    out_ready = 1'b1;
    push(make_entry(8'd3));
    for (int i = 0; i < 50; i++) begin
      tick();
      if (saw_last) begin
        busy_ok = (busy === 1'b0);
        break;
      end
      if (out_valid && out_ready) begin
        hs++;
        if (out_last) saw_last = 1;
      end
    end
    total++;
    if (hs !== 4 || !saw_last) begin
      bad++;
      $display("FAIL single_words: %0d words last_seen=%b, expected 4 with last", hs, saw_last);
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL single_busy: busy=%b after last word, expected 0", busy);
    end
    total++;
    if (words_seen - w0 !== 4 || err_seen !== e0) begin
      bad++;
      $display("FAIL single_count: words=%0d err=%0d, expected 4 and 0", words_seen - w0, err_seen - e0);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e;
    int hs = 0;
    int w1_cycles = 0;
    int w1_bad = 0;
    e = make_entry(8'd3);
    enable = 1'b1;
    out_ready = 1'b1;
    push(e);
    for (int i = 0; i < 60 && hs < 4; i++) begin
      tick();
      if (out_valid) begin
        if (hs == 1) begin
          w1_cycles++;
          if (out_data !== e[63:32]) w1_bad++;
          out_ready = (w1_cycles >= 4);
        end
        if (out_ready) hs++;
      end
    end
    out_ready = 1'b1;
    total++;
    if (w1_cycles !== 4 || w1_bad !== 0) begin
      bad++;
      $display("FAIL bp_hold: w1 shown %0d cycles (%0d wrong), expected 4 and 0", w1_cycles, w1_bad);
    end
    total++;
    if (hs !== 4) begin
      bad++;
      $display("FAIL bp_words: %0d words, expected 4", hs);
    end
    for (int i = 0; i < 20 && !drained(); i++) tick();
    total++;
    if (!drained()) begin
      bad++;
      $display("FAIL bp_drain: pending=%0d busy=%b, expected drained", exp_q.size(), busy);
    end
  endtask

  task automatic test_clamp();
    int hs = 0;
    int last_at = -1;
    int e0 = err_seen;
    int w0 = words_seen;
    enable = 1'b1;
    out_ready = 1'b1;
    push(make_entry(8'd200));
    for (int i = 0; i < 200 && !(hs > 0 && drained()); i++) begin
      tick();
      if (out_valid && out_ready) begin
        if (out_last) last_at = hs;
        hs++;
      end
    end
    total++;
    if (err_seen - e0 !== 1) begin
      bad++;
      $display("FAIL clamp_err: %0d pulses, expected 1", err_seen - e0);
    end
    total++;
    if (words_seen - w0 !== 64 || hs !== 64) begin
      bad++;
      $display("FAIL clamp_words: %0d words, expected 64", words_seen - w0);
    end
    total++;
    if (last_at !== 63) begin
      bad++;
      $display("FAIL clamp_last: last on word %0d, expected 63", last_at);
    end
  endtask

  task automatic test_idle();
    int bad_idle = 0;
    int bad_dis = 0;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
        bad++;
        bad_idle++;
        $display("FAIL idle_empty: rd=%b busy=%b, expected 0 0", fifo_rd_en, busy);
      end
    end
    enable = 1'b0;
    push(make_entry(8'd2));
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
        bad++;
        bad_dis++;
        $display("FAIL idle_disabled: rd=%b busy=%b, expected 0 0", fifo_rd_en, busy);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 30 && !drained(); i++) tick();
    total++;
    if (!drained()) begin
      bad++;
      $display("FAIL idle_drain: pending=%0d busy=%b, expected drained", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    int hs = 0;
    bit hit = 0;
    int w0;
    e = make_entry(8'd5);
    enable = 1'b1;
    out_ready = 1'b1;
    push(e);
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (out_valid && hs == 2) begin
        hit = 1;
        total++;
        if (out_data !== e[95:64]) begin
          bad++;
          $display("FAIL rstmid_word2: got %h, expected %h", out_data, e[95:64]);
        end
        rst = 1'b1;
      end else if (out_valid && out_ready) begin
        hs++;
      end
    end
    tick();
    rst = 1'b0;
    flush_model();
    #1;
    total++;
    if (!hit || out_valid !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd0) begin
      bad++;
      $display("FAIL rstmid_after: hit=%b valid=%b busy=%b cnt=%0d, expected 1 0 0 0", hit, out_valid, busy, pkt_count);
    end
    w0 = words_seen;
    push(make_entry(8'd2));
    for (int i = 0; i < 40 && !(words_seen > w0 && drained()); i++) tick();
    total++;
    if (words_seen - w0 !== 3 || !drained()) begin
      bad++;
      $display("FAIL rstmid_next: %0d words, expected 3 and drained", words_seen - w0);
    end
  endtask

  task automatic test_back_to_back();
    int rises = 0;
    int gap = 0;
    int min_gap = 1000;
    bit prev_busy = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush_model();
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(make_entry(8'd0));
    for (int i = 0; i < 60; i++) begin
      tick();
      if (busy && !prev_busy) begin
        rises++;
        if (rises > 1 && gap < min_gap) min_gap = gap;
      end
      if (!busy) gap++;
      else gap = 0;
      prev_busy = busy;
      if (rises == 3 && drained()) break;
    end
    total++;
    if (rises !== 3) begin
      bad++;
      $display("FAIL b2b_packets: %0d packets, expected 3", rises);
    end
    total++;
    if (min_gap < 1) begin
      bad++;
      $display("FAIL b2b_gap: min idle gap %0d cycles, expected at least 1", min_gap);
    end
`ifdef CMD_FIFO_READER_PKT_COUNT_EN
    total++;
    if (pkt_count !== 16'd3) begin
      bad++;
      $display("FAIL b2b_count: pkt_count=%0d, expected 3", pkt_count);
    end
`else
    total++;
    if (pkt_count !== 16'd0) begin
      bad++;
      $display("FAIL b2b_count: pkt_count=%0d, expected 0", pkt_count);
    end
`endif
  endtask

  task automatic test_random();
    int r;
    logic [7:0] len;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = 8'($urandom_range(64, 255));
      else if (r == 1) len = 8'd63;
      else len = 8'($urandom_range(0, 12));
      push(make_entry(len));
    end
    for (int i = 0; i < 30000 && !drained(); i++) begin
      tick();
      out_ready = ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 9) < 8);
    end
    enable = 1'b1;
    out_ready = 1'b1;
    total++;
    if (!drained()) begin
      bad++;
      $display("FAIL rand_drain: fifo_cnt=%0d pending=%0d busy=%b, expected drained", fifo_cnt, exp_q.size(), busy);
    end
    total++;
    if (err_seen !== err_exp) begin
      bad++;
      $display("FAIL rand_err: %0d pulses, expected %0d", err_seen, err_exp);
    end
`ifdef CMD_FIFO_READER_PKT_COUNT_EN
    total++;
    if (pkt_count !== pkt_exp) begin
      bad++;
      $display("FAIL rand_count: pkt_count=%0d, expected %0d", pkt_count, pkt_exp);
    end
`else
    total++;
    if (pkt_count !== 16'd0) begin
      bad++;
      $display("FAIL rand_count: pkt_count=%0d, expected 0", pkt_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_clamp();
    test_idle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
